// File: rtl/conv_pkg.sv
// Shared types and constants for the ternary 5x5 convolution datapath and its sequencer.
package conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int LAT_DEF = 6;
  localparam int DIM_W   = 8;
  localparam int KERN_W  = 50;

  // Kernel tap encoding, 2-bit signed: +1, -1, 0.
  localparam logic [1:0] TAP_POS  = 2'b01;
  localparam logic [1:0] TAP_NEG  = 2'b11;
  localparam logic [1:0] TAP_ZERO = 2'b00;

  function automatic logic [1:0] tap_at(input logic [KERN_W-1:0] kern, input int idx);
    return kern[2*idx +: 2];
  endfunction
endpackage

// File: rtl/conv_window_sched_if.sv
// Window request handshake towards the window buffer plus tagged result stream towards the writer.
interface conv_window_sched_if
  import conv_pkg::*;
  ();
  logic             win_valid;
  logic             win_ready;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic             res_valid;
  logic [DIM_W-1:0] res_row;
  logic [DIM_W-1:0] res_col;
  logic             res_last;

  modport master (
    output win_valid, win_row, win_col, res_valid, res_row, res_col, res_last,
    input  win_ready
  );
  modport slave (
    input  win_valid, win_row, win_col, res_valid, res_row, res_col, res_last,
    output win_ready
  );
endinterface

// File: rtl/conv_valid_pipe.sv
// LAT-stage valid shift register tracking in-flight windows; synchronous flush drops all of them.
module conv_valid_pipe #(
  parameter int LAT = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_vld,
  output logic out_vld
);
  logic [LAT-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = flush ? '0 : ((stage_q << 1) | LAT'(in_vld));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign out_vld = stage_q[LAT-1];
endmodule

// File: rtl/conv_window_sched.sv
// Raster-order window sequencer for the ternary conv datapath: one window per handshake,
// results tagged LAT cycles later with coordinates and last; win_ready low holds the request.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_out_w,
  input  logic [DIM_W-1:0]  cfg_out_h,
  input  logic [KERN_W-1:0] kernel_in,
  input  logic              kernel_we,
  output logic [KERN_W-1:0] kernel_out,
  output logic              busy,
  output logic              done,
  conv_window_sched_if.master win_if
);
  state_e            state_q, state_d;
  logic [KERN_W-1:0] kernel_q, kernel_d;
  logic [DIM_W-1:0]  cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
  logic [DIM_W-1:0]  win_row_q, win_row_d, win_col_q, win_col_d;
  logic [DIM_W-1:0]  res_row_q, res_row_d, res_col_q, res_col_d;
  logic              win_valid_q, win_valid_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              hs, flush, res_vld, res_last;
  logic              win_col_end, win_row_end, res_col_end;

  assign hs          = win_valid_q & win_if.win_ready;
  assign win_col_end = (win_col_q == cfg_w_q - DIM_W'(1));
  assign win_row_end = (win_row_q == cfg_h_q - DIM_W'(1));
  assign res_col_end = (res_col_q == cfg_w_q - DIM_W'(1));
  assign res_last    = res_vld & (res_row_q == cfg_h_q - DIM_W'(1)) & res_col_end;

  conv_valid_pipe #(.LAT(LAT)) u_valid_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .in_vld (hs),
    .out_vld(res_vld)
  );

  always_comb begin
    state_d     = state_q;
    kernel_d    = kernel_q;
    cfg_w_d     = cfg_w_q;
    cfg_h_d     = cfg_h_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    res_row_d   = res_row_q;
    res_col_d   = res_col_q;
    win_valid_d = win_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    flush       = 1'b0;

    // Results return in issue order, so a second raster counter recovers their coordinates.
    if (res_vld) begin
      if (res_col_end) begin
        res_col_d = '0;
        res_row_d = res_row_q + DIM_W'(1);
      end else begin
        res_col_d = res_col_q + DIM_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (kernel_we) kernel_d = kernel_in;
        if (start) begin
          cfg_w_d     = cfg_out_w;
          cfg_h_d     = cfg_out_h;
          win_row_d   = '0;
          win_col_d   = '0;
          res_row_d   = '0;
          res_col_d   = '0;
          busy_d      = 1'b1;
          win_valid_d = (cfg_out_w != '0) && (cfg_out_h != '0);
          state_d     = RUN;
        end
      end
      RUN: begin
        if (abort || cfg_w_q == '0 || cfg_h_q == '0) begin
          flush       = abort;
          win_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else if (hs) begin
          if (win_col_end) begin
            win_col_d = '0;
            win_row_d = win_row_q + DIM_W'(1);
            if (win_row_end) begin
              win_valid_d = 1'b0;
              state_d     = DRAIN;
            end
          end else begin
            win_col_d = win_col_q + DIM_W'(1);
          end
        end
      end
      DRAIN: begin
        if (abort || res_last) begin
          flush   = abort;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kernel_q    <= '0;
      cfg_w_q     <= '0;
      cfg_h_q     <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kernel_q    <= kernel_d;
      cfg_w_q     <= cfg_w_d;
      cfg_h_q     <= cfg_h_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      res_row_q   <= res_row_d;
      res_col_q   <= res_col_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign kernel_out       = kernel_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign win_if.win_valid = win_valid_q;
  assign win_if.win_row   = win_row_q;
  assign win_if.win_col   = win_col_q;
  assign win_if.res_valid = res_vld;
  assign win_if.res_row   = res_row_q;
  assign win_if.res_col   = res_col_q;
  assign win_if.res_last  = res_last;
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: raster passes, backpressure, kernel load, abort, zero map, reset.
module tb_conv_window_sched;
  localparam int LAT = 6;
  localparam logic [49:0] KERN_A = 50'h2AAAAAAAAAAAA;
  localparam logic [49:0] KERN_B = 50'h1555555555555;
  localparam logic [49:0] KERN_C = 50'h0F0F0F0F0F0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_out_w = '0;
  logic [7:0]  cfg_out_h = '0;
  logic [49:0] kernel_in = '0;
  logic        kernel_we = 1'b0;
  logic [49:0] kernel_out;
  logic        busy, done;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  conv_window_sched_if win_if();

  conv_window_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_out_w (cfg_out_w),
    .cfg_out_h (cfg_out_h),
    .kernel_in (kernel_in),
    .kernel_we (kernel_we),
    .kernel_out(kernel_out),
    .busy      (busy),
    .done      (done),
    .win_if    (win_if)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_kernel"}, kernel_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_win_valid"}, win_if.win_valid, 0);
    chk({tag, "_win_rc"}, {win_if.win_row, win_if.win_col}, 0);
    chk({tag, "_res_valid"}, win_if.res_valid, 0);
    chk({tag, "_res_last"}, win_if.res_last, 0);
    chk({tag, "_res_rc"}, {win_if.res_row, win_if.res_col}, 0);
  endtask

  // mode 0: win_ready held high; mode 1: win_ready toggles 1,0,1,0 from the first RUN cycle.
  task automatic run_pass(input int w, input int h, input int mode);
    int nhs = 0, nres = 0, last_res = -100, t0, t_run;
    int hs_cyc[$];
    bit got_done = 1'b0;
    cfg_out_w = 8'(w);
    cfg_out_h = 8'(h);
    win_if.win_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    kernel_we = 1'b0;
    t_run = cyc;
    chk("busy_in_run", busy, 1);
    for (int i = 0; i < 400 && !got_done; i++) begin
      win_if.win_ready = (mode == 0) ? 1'b1 : (i % 2 == 0);
      chk("win_valid", win_if.win_valid, (nhs < w * h) ? 1 : 0);
      if (win_if.win_valid) begin
        chk("win_row", win_if.win_row, nhs / w);
        chk("win_col", win_if.win_col, nhs % w);
        if (win_if.win_ready) begin
          if (mode == 0) chk("hs_cycle", cyc - t_run, nhs);
          hs_cyc.push_back(cyc);
          nhs++;
        end
      end
      if (win_if.res_valid) begin
        chk("res_row", win_if.res_row, nres / w);
        chk("res_col", win_if.res_col, nres % w);
        chk("res_last", win_if.res_last, (nres == w * h - 1) ? 1 : 0);
        if (hs_cyc.size() > 0) chk("res_latency", cyc - hs_cyc.pop_front(), LAT);
        else chk("res_without_hs", 1, 0);
        if (win_if.res_last) last_res = cyc;
        nres++;
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_after_last", cyc - last_res, 1);
        if (mode == 0) chk("done_cycle", cyc - t0, w * h + LAT + 1);
      end
      step();
    end
    chk("done_seen", got_done, 1);
    chk("hs_count", nhs, w * h);
    chk("res_count", nres, w * h);
    chk("done_single", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int dn, rv, wv, t0, done_at;
    win_if.win_ready = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Kernel load in IDLE.
    kernel_in = KERN_A;
    kernel_we = 1'b1;
    step();
    kernel_we = 1'b0;
    chk("kernel_load", kernel_out, KERN_A);

    run_pass(3, 2, 0);
    run_pass(4, 4, 1);

    // Minimum 1x1 pass with a kernel write in the start cycle.
    kernel_in = KERN_B;
    kernel_we = 1'b1;
    run_pass(1, 1, 0);
    chk("kernel_with_start", kernel_out, KERN_B);

    // Abort 3 cycles into an 8x8 pass; kernel write during RUN is ignored.
    cfg_out_w = 8'd8;
    cfg_out_h = 8'd8;
    win_if.win_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    kernel_in = KERN_C;
    kernel_we = 1'b1;
    step();
    kernel_we = 1'b0;
    step();
    chk("kernel_held_run", kernel_out, KERN_B);
    chk("win_valid_pre_abort", win_if.win_valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_win_valid", win_if.win_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    dn = 0; rv = 0; wv = 0;
    for (int i = 0; i < 20; i++) begin
      dn += int'(done);
      rv += int'(win_if.res_valid);
      wv += int'(win_if.win_valid);
      step();
    end
    chk("abort_done_pulses", dn, 1);
    chk("abort_res_after", rv, 0);
    chk("abort_win_after", wv, 0);

    // Zero-width map.
    cfg_out_w = 8'd0;
    cfg_out_h = 8'd4;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    wv = 0;
    done_at = -1;
    for (int i = 0; i < 10; i++) begin
      wv += int'(win_if.win_valid);
      if (done && done_at < 0) done_at = cyc - t0;
      step();
    end
    chk("zero_win_valid", wv, 0);
    chk("zero_done_cycle", done_at, 2);

    // Reset during DRAIN of a 3x3 pass.
    cfg_out_w = 8'd3;
    cfg_out_h = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("drain_busy", busy, 1);
    chk("drain_win_valid", win_if.win_valid, 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    #1 rst_n = 1'b1;
    step();
    run_pass(2, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
